// File: rtl/vfu_queue_pkg.sv
// Shared types for the VFU request queue.
// Request payload layout and tag type used between the slot arbiter and a lane VFU.
package vfu_queue_pkg;

   localparam int unsigned PAYLOAD_W = 204;
   localparam int unsigned NUM_TAGS  = 4;

   typedef logic [1:0] vfu_tag_t;

   // 204 bits, first field lands in the MSBs
   typedef struct packed {
      logic [31:0] src_0;
      logic [31:0] src_1;
      logic [31:0] src_2;
      logic [31:0] src_3;
      logic [5:0]  opcode;
      logic [3:0]  mask;
      logic [3:0]  executeMask;
      logic [3:0]  ctrl;
      logic [1:0]  vxrm;
      logic [1:0]  vSew;
      logic [3:0]  shifterSize;
      logic [5:0]  rem;
      logic [1:0]  executeIndex;
      logic [23:0] popInit;
      logic [4:0]  groupIndex;
      logic [4:0]  laneIndex;
      logic        maskType;
      logic        narrow;
      logic [1:0]  unitSelet;
      logic        floatMul;
      logic [2:0]  roundingMode;
   } slot_req_payload_t;

   function automatic vfu_tag_t to_tag(input int unsigned t);
      return vfu_tag_t'(t);
   endfunction

endpackage

// File: rtl/vfu_request_fifo.sv
// Generic synchronous FIFO with occupancy output.
// No bypass: a pushed entry is readable from the following cycle.
module vfu_request_fifo #(
   parameter int unsigned WIDTH    = 206,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [WIDTH-1:0]    data_i,
   output logic [WIDTH-1:0]    data_o,
   output logic [CNT_BITS-1:0] count_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [PW-1:0]       wr_q, wr_d;
   logic [PW-1:0]       rd_q, rd_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = bump(wr_q);
      if (pop_i)  rd_d = bump(rd_q);
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // storage needs no reset; validity is tracked by cnt_q
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign full_o  = (cnt_q == CNT_BITS'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/vfu_request_queue.sv
// Request FIFO between slot arbiter and lane VFU.
// Tracks in-flight requests per tag and throttles enqueue at MAX_INFLIGHT.
module vfu_request_queue
   import vfu_queue_pkg::*;
#(
   parameter int unsigned PAYLOAD_W    = vfu_queue_pkg::PAYLOAD_W,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned MAX_INFLIGHT = 3,
   parameter int unsigned CNT_W        = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enq_valid,
   output logic                         enq_ready,
   input  logic [PAYLOAD_W-1:0]         enq_bits_payload,
   input  logic [1:0]                   enq_bits_tag,
   output logic                         deq_valid,
   input  logic                         deq_ready,
   output logic [PAYLOAD_W-1:0]         deq_bits_payload,
   output logic [1:0]                   deq_bits_tag,
   input  logic                         resp_valid,
   input  logic [1:0]                   resp_tag,
   output logic [CNT_W-1:0]             inflight_0,
   output logic [CNT_W-1:0]             inflight_1,
   output logic [CNT_W-1:0]             inflight_2,
   output logic [CNT_W-1:0]             inflight_3,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         idle,
   output logic                         resp_underflow
);

   localparam int unsigned CB = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0]    infl_q [NUM_TAGS];
   logic [CNT_W-1:0]    infl_d [NUM_TAGS];
   logic [NUM_TAGS-1:0] inc_v, dec_v;
   logic                unf_q, unf_d;
   logic                full, empty, enq_fire, deq_fire, busy;
   logic [PAYLOAD_W+1:0] rd_data;
   logic [CB-1:0]       fifo_cnt;

   assign enq_ready = reset & ~full & (infl_q[enq_bits_tag] < MAX_C);
   // gated by reset so the VFU never sees a handshake in a reset cycle
   assign deq_valid = reset & ~empty;
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;

   vfu_request_fifo #(
      .WIDTH    (PAYLOAD_W + 2),
      .DEPTH    (DEPTH),
      .CNT_BITS (CB)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (enq_fire),
      .pop_i   (deq_fire),
      .data_i  ({enq_bits_tag, enq_bits_payload}),
      .data_o  (rd_data),
      .count_o (fifo_cnt),
      .full_o  (full),
      .empty_o (empty)
   );

   assign deq_bits_tag     = rd_data[PAYLOAD_W+1:PAYLOAD_W];
   assign deq_bits_payload = rd_data[PAYLOAD_W-1:0];
   assign count            = fifo_cnt;

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      if (enq_fire)   inc_v[enq_bits_tag] = 1'b1;
      if (resp_valid) dec_v[resp_tag]     = 1'b1;
      for (int t = 0; t < NUM_TAGS; t++) begin
         infl_d[t] = infl_q[t];
         if (inc_v[t] && !dec_v[t])
            infl_d[t] = infl_q[t] + 1'b1;
         else if (dec_v[t] && !inc_v[t] && infl_q[t] != '0)
            infl_d[t] = infl_q[t] - 1'b1;
      end
      unf_d = unf_q | (resp_valid & (infl_q[resp_tag] == '0));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int t = 0; t < NUM_TAGS; t++) infl_q[t] <= '0;
         unf_q <= 1'b0;
      end else begin
         for (int t = 0; t < NUM_TAGS; t++) infl_q[t] <= infl_d[t];
         unf_q <= unf_d;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int t = 0; t < NUM_TAGS; t++)
         if (infl_q[t] != '0) busy = 1'b1;
   end

   assign idle           = empty & ~busy;
   assign inflight_0     = infl_q[0];
   assign inflight_1     = infl_q[1];
   assign inflight_2     = infl_q[2];
   assign inflight_3     = infl_q[3];
   assign resp_underflow = unf_q;

endmodule

// File: tb/tb_vfu_request_queue.sv
// Directed bench for vfu_request_queue (DEPTH=2, MAX_INFLIGHT=3).
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_vfu_request_queue;

   localparam int PW = 204;

   logic          clock = 1'b0;
   logic          reset;
   logic          enq_valid;
   logic          enq_ready;
   logic [PW-1:0] enq_bits_payload;
   logic [1:0]    enq_bits_tag;
   logic          deq_valid;
   logic          deq_ready;
   logic [PW-1:0] deq_bits_payload;
   logic [1:0]    deq_bits_tag;
   logic          resp_valid;
   logic [1:0]    resp_tag;
   logic [1:0]    inflight_0, inflight_1, inflight_2, inflight_3;
   logic [1:0]    count;
   logic          idle;
   logic          resp_underflow;

   int n_run  = 0;
   int n_fail = 0;

   logic [PW-1:0] p0, p1, p2, p3, p4;

   vfu_request_queue #(
      .PAYLOAD_W    (PW),
      .DEPTH        (2),
      .MAX_INFLIGHT (3),
      .CNT_W        (2)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .enq_valid        (enq_valid),
      .enq_ready        (enq_ready),
      .enq_bits_payload (enq_bits_payload),
      .enq_bits_tag     (enq_bits_tag),
      .deq_valid        (deq_valid),
      .deq_ready        (deq_ready),
      .deq_bits_payload (deq_bits_payload),
      .deq_bits_tag     (deq_bits_tag),
      .resp_valid       (resp_valid),
      .resp_tag         (resp_tag),
      .inflight_0       (inflight_0),
      .inflight_1       (inflight_1),
      .inflight_2       (inflight_2),
      .inflight_3       (inflight_3),
      .count            (count),
      .idle             (idle),
      .resp_underflow   (resp_underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [PW-1:0] obs,
                      input logic [PW-1:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      p0 = {51{4'hA}};
      p1 = {51{4'h5}};
      p2 = {51{4'h3}};
      p3 = {51{4'hC}};
      p4 = {51{4'h9}};
      reset = 1'b0; enq_valid = 1'b1; enq_bits_tag = 2'd0;
      enq_bits_payload = '0; deq_ready = 1'b0;
      resp_valid = 1'b0; resp_tag = 2'd0;

      // reset held two cycles
      tick();
      chk("rst_enq_ready", enq_ready, 0);
      tick();
      reset = 1'b1; enq_valid = 1'b0;
      settle();
      chk("idle_enq_ready", enq_ready, 1);
      chk("idle_deq_valid", deq_valid, 0);
      chk("idle_count", count, 0);
      chk("idle_idle", idle, 1);
      chk("idle_inflight", {inflight_3, inflight_2, inflight_1, inflight_0}, 0);
      chk("idle_unf", resp_underflow, 0);

      // latency and order
      enq_valid = 1'b1; enq_bits_tag = 2'd0; enq_bits_payload = p0;
      deq_ready = 1'b1;
      settle();
      chk("lat_no_bypass", deq_valid, 0);
      tick();
      enq_bits_tag = 2'd1; enq_bits_payload = p1;
      settle();
      chk("lat_deq_valid", deq_valid, 1);
      chk("lat_tag0", deq_bits_tag, 0);
      chk("lat_pay0", deq_bits_payload, p0);
      tick();
      enq_valid = 1'b0;
      settle();
      chk("ord_tag1", deq_bits_tag, 1);
      chk("ord_pay1", deq_bits_payload, p1);
      chk("ord_count", count, 1);
      chk("ord_infl0", inflight_0, 1);
      chk("ord_infl1", inflight_1, 1);
      tick();
      chk("drain_deq_valid", deq_valid, 0);
      chk("drain_idle", idle, 0);
      resp_valid = 1'b1; resp_tag = 2'd0;
      tick();
      resp_tag = 2'd1;
      tick();
      resp_valid = 1'b0;
      settle();
      chk("resp_idle", idle, 1);
      chk("resp_unf", resp_underflow, 0);

      // full FIFO, no pass-through
      deq_ready = 1'b0;
      enq_valid = 1'b1; enq_bits_tag = 2'd3; enq_bits_payload = p2;
      tick();
      enq_bits_payload = p3;
      tick();
      enq_bits_tag = 2'd0; enq_bits_payload = p4;
      settle();
      chk("full_count", count, 2);
      chk("full_enq_ready", enq_ready, 0);
      chk("full_infl3", inflight_3, 2);
      deq_ready = 1'b1;
      settle();
      chk("full_deq_enq_ready", enq_ready, 0);
      chk("full_head", deq_bits_payload, p2);
      tick();
      chk("after_full_count", count, 1);
      chk("after_full_enq_ready", enq_ready, 1);
      chk("after_full_head", deq_bits_payload, p3);
      tick();
      enq_valid = 1'b0;
      settle();
      chk("bothfire_count", count, 1);
      chk("bothfire_tag", deq_bits_tag, 0);
      chk("bothfire_pay", deq_bits_payload, p4);
      tick();
      chk("full_drain", count, 0);
      resp_valid = 1'b1; resp_tag = 2'd3;
      tick();
      tick();
      resp_tag = 2'd0;
      tick();
      resp_valid = 1'b0;
      settle();
      chk("full_idle", idle, 1);

      // per-tag throttle
      enq_valid = 1'b1; enq_bits_tag = 2'd2; enq_bits_payload = p1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("thr_accept", enq_ready, 1);
         tick();
      end
      enq_valid = 1'b0;
      tick();
      chk("thr_count", count, 0);
      chk("thr_infl2", inflight_2, 3);
      chk("thr_block2", enq_ready, 0);
      enq_bits_tag = 2'd3;
      settle();
      chk("thr_allow3", enq_ready, 1);
      resp_valid = 1'b1; resp_tag = 2'd2;
      tick();
      resp_valid = 1'b0;
      enq_bits_tag = 2'd2;
      settle();
      chk("thr_infl2_dec", inflight_2, 2);
      chk("thr_reopen", enq_ready, 1);
      enq_valid = 1'b1;
      tick();
      enq_valid = 1'b0;
      settle();
      chk("thr_reenq", inflight_2, 3);
      tick();
      resp_valid = 1'b1; resp_tag = 2'd2;
      tick();
      tick();
      tick();
      resp_valid = 1'b0;
      settle();
      chk("thr_clear", idle, 1);

      // simultaneous events and underflow
      enq_valid = 1'b1; enq_bits_tag = 2'd1; enq_bits_payload = p0;
      tick();
      resp_valid = 1'b1; resp_tag = 2'd1;
      tick();
      enq_valid = 1'b0;
      resp_tag = 2'd0;
      settle();
      chk("sim_infl1", inflight_1, 1);
      tick();
      resp_valid = 1'b0;
      settle();
      chk("unf_infl0", inflight_0, 0);
      chk("unf_set", resp_underflow, 1);
      tick();
      chk("unf_sticky", resp_underflow, 1);
      resp_valid = 1'b1; resp_tag = 2'd1;
      tick();
      resp_valid = 1'b0;

      // reset mid-operation
      deq_ready = 1'b0;
      enq_valid = 1'b1; enq_bits_tag = 2'd3; enq_bits_payload = p2;
      tick();
      tick();
      enq_valid = 1'b0;
      settle();
      chk("mid_count", count, 2);
      chk("mid_infl3", inflight_3, 2);
      reset = 1'b0; deq_ready = 1'b1; enq_valid = 1'b1;
      settle();
      chk("mid_no_deq_fire", deq_valid, 0);
      chk("mid_enq_ready", enq_ready, 0);
      tick();
      reset = 1'b1; deq_ready = 1'b0; enq_valid = 1'b0;
      settle();
      chk("mid_count_clr", count, 0);
      chk("mid_deq_valid", deq_valid, 0);
      chk("mid_infl_clr", {inflight_3, inflight_2, inflight_1, inflight_0}, 0);
      chk("mid_unf_clr", resp_underflow, 0);
      chk("mid_idle", idle, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
